// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one combinational 8-bit ALU between two requesters.
// Optional sticky flag accumulator is enabled with `define ALU_STICKY_FLAGS_EN.
module alu_rr_arbiter #(
   parameter int unsigned ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [2:0] req0_op,
   output logic       resp0_valid,
   input  logic       resp0_ready,
   output logic [7:0] resp0_result,
   output logic [2:0] resp0_flags,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [2:0] req1_op,
   output logic       resp1_valid,
   input  logic       resp1_ready,
   output logic [7:0] resp1_result,
   output logic [2:0] resp1_flags,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_opcode,
   input  logic [7:0] alu_result,
   input  logic       alu_carry,
   input  logic       alu_zero,
   input  logic       alu_overflow,
`ifdef ALU_STICKY_FLAGS_EN
   input  logic       sticky_clr,
   output logic [2:0] sticky_flags,
`endif
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e     state_q, state_d;
   logic [3:0] lat_cnt_q, lat_cnt_d;
   logic       last_grant_q;
   logic       owner_q;
   logic       gnt0, gnt1, accept, capture, resp_hs;
   logic [2:0] alu_flags;

   assign alu_flags = {alu_overflow, alu_carry, alu_zero};

   // On contention the port that was not granted last wins.
   assign gnt0    = req0_valid && (!req1_valid || last_grant_q);
   assign gnt1    = req1_valid && (!req0_valid || !last_grant_q);
   assign accept  = (state_q == IDLE) && (gnt0 || gnt1);
   assign capture = (state_q == EXEC) && (lat_cnt_q == 4'd0);
   assign resp_hs = (state_q == RESP) && (owner_q ? resp1_ready : resp0_ready);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         lat_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

   // NOTE: every output of a combinational block is given a default first so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d   = EXEC;
            lat_cnt_d = 4'(ALU_LAT - 1);
         end
         EXEC: if (lat_cnt_q == 4'd0) state_d = RESP;
               else                   lat_cnt_d = lat_cnt_q - 4'd1;
         RESP: if (resp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q != IDLE);
      req0_ready  = (state_q == IDLE) && gnt0;
      req1_ready  = (state_q == IDLE) && gnt1;
      resp0_valid = (state_q == RESP) && !owner_q;
      resp1_valid = (state_q == RESP) &&  owner_q;
   end

   // Operand issue and grant bookkeeping; alu_* hold their values outside accepts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a        <= 8'd0;
         alu_b        <= 8'd0;
         alu_opcode   <= 3'd0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else if (accept) begin
         alu_a        <= gnt1 ? req1_a  : req0_a;
         alu_b        <= gnt1 ? req1_b  : req0_b;
         alu_opcode   <= gnt1 ? req1_op : req0_op;
         owner_q      <= gnt1;
         last_grant_q <= gnt1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp0_result <= 8'd0;
         resp0_flags  <= 3'd0;
         resp1_result <= 8'd0;
         resp1_flags  <= 3'd0;
      end else if (capture) begin
         if (owner_q) begin
            resp1_result <= alu_result;
            resp1_flags  <= alu_flags;
         end else begin
            resp0_result <= alu_result;
            resp0_flags  <= alu_flags;
         end
      end
   end

`ifdef ALU_STICKY_FLAGS_EN
   // A clear coinciding with a capture keeps only the new op's flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           sticky_flags <= 3'd0;
      else if (capture)     sticky_flags <= sticky_clr ? alu_flags : (sticky_flags | alu_flags);
      else if (sticky_clr)  sticky_flags <= 3'd0;
   end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural ALU behind two instances (ALU_LAT=1 and 3).
module tb_alu_rr_arbiter;

   logic clk, rst_n;
   int   vectors     = 0;
   int   miscompares = 0;

   // ALU_LAT = 1 instance
   logic       req0_valid, req0_ready, resp0_valid, resp0_ready;
   logic       req1_valid, req1_ready, resp1_valid, resp1_ready;
   logic [7:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
   logic [2:0] req0_op, req1_op, resp0_flags, resp1_flags;
   logic [7:0] alu_a, alu_b, alu_result;
   logic [2:0] alu_opcode;
   logic       alu_carry, alu_zero, alu_overflow, busy;

   // ALU_LAT = 3 instance
   logic       req0_valid_3, req0_ready_3, resp0_valid_3, resp0_ready_3;
   logic       req1_valid_3, req1_ready_3, resp1_valid_3, resp1_ready_3;
   logic [7:0] req0_a_3, req0_b_3, req1_a_3, req1_b_3, resp0_result_3, resp1_result_3;
   logic [2:0] req0_op_3, req1_op_3, resp0_flags_3, resp1_flags_3;
   logic [7:0] alu_a_3, alu_b_3, alu_result_3;
   logic [2:0] alu_opcode_3;
   logic       alu_carry_3, alu_zero_3, alu_overflow_3, busy_3;

`ifdef ALU_STICKY_FLAGS_EN
   logic       sticky_clr, sticky_clr_3;
   logic [2:0] sticky_flags, sticky_flags_3;
`endif

   function automatic logic [10:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
      logic [8:0] s;
      logic [7:0] r;
      logic       c, v;
      s = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                     v = (a[7] == b[7]) && (r[7] != a[7]); end
         3'd3: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
                     v = (a[7] != b[7]) && (r[7] != a[7]); end
         3'd4: begin r = a << 1; c = a[7]; end
         3'd5: begin r = a >> 1; c = a[0]; end
         3'd6: r = ~a;
         default: r = a ^ b;
      endcase
      return {v, c, (r == 8'd0), r};
   endfunction

   assign {alu_overflow, alu_carry, alu_zero, alu_result} = alu_model(alu_a, alu_b, alu_opcode);
   assign {alu_overflow_3, alu_carry_3, alu_zero_3, alu_result_3} =
          alu_model(alu_a_3, alu_b_3, alu_opcode_3);

   alu_rr_arbiter #(.ALU_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_op(req0_op), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp0_result(resp0_result), .resp0_flags(resp0_flags),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_op(req1_op), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp1_result(resp1_result), .resp1_flags(resp1_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
      .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
`ifdef ALU_STICKY_FLAGS_EN
      .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
`endif
      .busy(busy)
   );

   alu_rr_arbiter #(.ALU_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid_3), .req0_ready(req0_ready_3), .req0_a(req0_a_3), .req0_b(req0_b_3),
      .req0_op(req0_op_3), .resp0_valid(resp0_valid_3), .resp0_ready(resp0_ready_3),
      .resp0_result(resp0_result_3), .resp0_flags(resp0_flags_3),
      .req1_valid(req1_valid_3), .req1_ready(req1_ready_3), .req1_a(req1_a_3), .req1_b(req1_b_3),
      .req1_op(req1_op_3), .resp1_valid(resp1_valid_3), .resp1_ready(resp1_ready_3),
      .resp1_result(resp1_result_3), .resp1_flags(resp1_flags_3),
      .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_opcode(alu_opcode_3), .alu_result(alu_result_3),
      .alu_carry(alu_carry_3), .alu_zero(alu_zero_3), .alu_overflow(alu_overflow_3),
`ifdef ALU_STICKY_FLAGS_EN
      .sticky_clr(sticky_clr_3), .sticky_flags(sticky_flags_3),
`endif
      .busy(busy_3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete req0 transaction on the ALU_LAT=1 instance.
   task automatic op0(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] exp_r, input logic [2:0] exp_f);
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
      #1;
      check("op0_ready", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      step();
      check("op0_valid",  32'(resp0_valid),  32'd1);
      check("op0_result", 32'(resp0_result), 32'(exp_r));
      check("op0_flags",  32'(resp0_flags),  32'(exp_f));
      resp0_ready = 1'b1;
      step();
      resp0_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; resp0_ready = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; resp1_ready = 0;
      req0_valid_3 = 0; req0_a_3 = 0; req0_b_3 = 0; req0_op_3 = 0; resp0_ready_3 = 0;
      req1_valid_3 = 0; req1_a_3 = 0; req1_b_3 = 0; req1_op_3 = 0; resp1_ready_3 = 0;
`ifdef ALU_STICKY_FLAGS_EN
      sticky_clr = 0; sticky_clr_3 = 0;
`endif
      step(); step();

      // Reset state
      check("rst_busy",   32'(busy),         32'd0);
      check("rst_rdy0",   32'(req0_ready),   32'd0);
      check("rst_rdy1",   32'(req1_ready),   32'd0);
      check("rst_rv0",    32'(resp0_valid),  32'd0);
      check("rst_alu_a",  32'(alu_a),        32'd0);
      check("rst_res0",   32'(resp0_result), 32'd0);
      rst_n = 1'b1;
      step();

      // 1: ADD 200+100, response two cycles after the accept cycle
      req0_a = 8'd200; req0_b = 8'd100; req0_op = 3'd2; req0_valid = 1'b1;
      #1;
      check("t1_rdy0", 32'(req0_ready), 32'd1);
      check("t1_rdy1", 32'(req1_ready), 32'd0);
      step();
      req0_valid = 1'b0;
      check("t1_busy",  32'(busy),        32'd1);
      check("t1_alu_a", 32'(alu_a),       32'd200);
      check("t1_alu_b", 32'(alu_b),       32'd100);
      check("t1_alu_op",32'(alu_opcode),  32'd2);
      check("t1_rv0_e", 32'(resp0_valid), 32'd0);
      step();
      check("t1_rv0",   32'(resp0_valid),  32'd1);
      check("t1_res",   32'(resp0_result), 32'd44);
      check("t1_flags", 32'(resp0_flags),  32'b010);
      check("t1_rv1",   32'(resp1_valid),  32'd0);
      check("t1_rdy0x", 32'(req0_ready),   32'd0);
      resp0_ready = 1'b1;
      step();
      resp0_ready = 1'b0;
      check("t1_rv0_off", 32'(resp0_valid),  32'd0);
      check("t1_idle",    32'(busy),         32'd0);
      check("t1_hold",    32'(resp0_result), 32'd44);

      // 2: both valid from reset, grants alternate 0,1,0,1
      rst_n = 1'b0; step(); rst_n = 1'b1; step();
      req0_a = 8'h0F; req0_b = 8'hF0; req0_op = 3'd0;
      req1_a = 8'h55; req1_b = 8'hFF; req1_op = 3'd7;
      req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_rdy0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("t2_rdy1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
         step();
         step();
         if (i % 2 == 0) begin
            check("t2_rv0",  32'(resp0_valid),  32'd1);
            check("t2_rv1x", 32'(resp1_valid),  32'd0);
            check("t2_res0", 32'(resp0_result), 32'h00);
            check("t2_fl0",  32'(resp0_flags),  32'b001);
         end else begin
            check("t2_rv1",  32'(resp1_valid),  32'd1);
            check("t2_rv0x", 32'(resp0_valid),  32'd0);
            check("t2_res1", 32'(resp1_result), 32'hAA);
            check("t2_fl1",  32'(resp1_flags),  32'b000);
         end
         step();
      end

      // 3: response back-pressure holds everything stable
      req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
      req0_a = 8'h12; req0_b = 8'h21; req0_op = 3'd1;
      #1;
      check("t3_rdy0", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      step();
      req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t3_rv0",  32'(resp0_valid),  32'd1);
         check("t3_res",  32'(resp0_result), 32'h33);
         check("t3_rdy0", 32'(req0_ready),   32'd0);
         check("t3_rdy1", 32'(req1_ready),   32'd0);
         check("t3_busy", 32'(busy),         32'd1);
         step();
      end
      req1_valid = 1'b0; resp0_ready = 1'b1;
      step();
      resp0_ready = 1'b0;
      check("t3_rv0_off", 32'(resp0_valid), 32'd0);

      // 4: reset during EXEC discards the op; next grant goes to req0
      req0_a = 8'd5; req0_b = 8'd10; req0_op = 3'd3; req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      check("t4_busy_e",  32'(busy),       32'd1);
      check("t4_op_e",    32'(alu_opcode), 32'd3);
      rst_n = 1'b0;
      #1;
      check("t4_busy",    32'(busy),         32'd0);
      check("t4_alu_a",   32'(alu_a),        32'd0);
      check("t4_alu_b",   32'(alu_b),        32'd0);
      check("t4_alu_op",  32'(alu_opcode),   32'd0);
      check("t4_rv0",     32'(resp0_valid),  32'd0);
      check("t4_res0",    32'(resp0_result), 32'd0);
      step();
      rst_n = 1'b1;
      step(); step();
      check("t4_no_resp", 32'(resp0_valid), 32'd0);
      check("t4_idle",    32'(busy),        32'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("t4_rdy0", 32'(req0_ready), 32'd1);
      check("t4_rdy1", 32'(req1_ready), 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      op0(8'd5, 8'd10, 3'd3, 8'hFB, 3'b010);

      // 5: ALU_LAT=3 holds operands three cycles, response four cycles after accept
      req0_a_3 = 8'h10; req0_b_3 = 8'h20; req0_op_3 = 3'd2; req0_valid_3 = 1'b1;
      #1;
      check("t5_rdy0", 32'(req0_ready_3), 32'd1);
      step();
      req0_valid_3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t5_alu_a",  32'(alu_a_3),       32'h10);
         check("t5_alu_b",  32'(alu_b_3),       32'h20);
         check("t5_alu_op", 32'(alu_opcode_3),  32'd2);
         check("t5_rv0_e",  32'(resp0_valid_3), 32'd0);
         step();
      end
      check("t5_rv0",   32'(resp0_valid_3),  32'd1);
      check("t5_res",   32'(resp0_result_3), 32'h30);
      check("t5_flags", 32'(resp0_flags_3),  32'b000);

`ifdef ALU_STICKY_FLAGS_EN
      // 6: sticky accumulation, explicit clear, clear coinciding with a capture
      rst_n = 1'b0; step();
      check("t6_rst", 32'(sticky_flags), 32'd0);
      rst_n = 1'b1; step();
      op0(8'd200, 8'd100, 3'd2, 8'd44, 3'b010);
      op0(8'h0F, 8'hF0, 3'd0, 8'h00, 3'b001);
      check("t6_accum", 32'(sticky_flags), 32'b011);
      req0_a = 8'h80; req0_b = 8'h01; req0_op = 3'd3; req0_valid = 1'b1;
      step();
      req0_valid = 1'b0; sticky_clr = 1'b1;
      step();
      sticky_clr = 1'b0;
      check("t6_clr_cap", 32'(sticky_flags), 32'b100);
      check("t6_sub_res", 32'(resp0_result), 32'h7F);
      resp0_ready = 1'b1; step(); resp0_ready = 1'b0;
      sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
      check("t6_clr", 32'(sticky_flags), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
